mips_cpu_muldiv: RTL
====================

MIPS_CPU_MULDIV -- requirements
Module: mips_cpu_muldiv

Interface
REQ-001 SHALL: parameters: none.
REQ-002 SHALL: one clock; reset is asynchronous and active-high.
REQ-003 SHALL: clk  input  1  rising-edge system clock.
REQ-004 SHALL: reset  input  1  asynchronous active-high reset.
REQ-005 SHALL: start  input  1  request a new operation, sampled at posedge.
REQ-006 SHALL: op  input  2  00=MULT, 01=MULTU, 10=DIV, 11=DIVU.
REQ-007 SHALL: op_a  input  32  rs operand, multiplicand or dividend.
REQ-008 SHALL: op_b  input  32  rt operand, multiplier or divisor.
REQ-009 SHALL: hi_we  input  1  MTHI write strobe.
REQ-010 SHALL: lo_we  input  1  MTLO write strobe.
REQ-011 SHALL: wdata  input  32  MTHI/MTLO data.
REQ-012 SHALL: busy  output  1  operation in progress; CPU stalls MFHI/MFLO while high.
REQ-013 SHALL: done  output  1  one-cycle completion pulse.
REQ-014 SHALL: hi  output  32  HI register; MFHI source.
REQ-015 SHALL: lo  output  32  LO register; MFLO source.

Function
REQ-016 SHALL: FSM states are IDLE, BUSY and FIX.
- IDLE -> BUSY on start.
- BUSY -> FIX after exactly 32 iteration edges.
- FIX -> IDLE unconditionally.
REQ-017 SHALL: on the accepting edge, latch op, operand magnitudes (signed ops) or raw values (unsigned ops), and the result sign flags.
REQ-018 SHALL: multiply is radix-2 shift-add over 32 iterations and produces a 64-bit product, with HI=[63:32] and LO=[31:0].
REQ-019 SHALL: divide is radix-2 restoring over 32 iterations; LO=quotient, HI=remainder.
REQ-020 SHALL: the signed quotient truncates toward zero; the remainder takes the sign of the dividend.
REQ-021 SHALL: FIX applies sign correction and writes hi/lo on the FIX->IDLE edge; done is high for exactly the cycle after that edge.
REQ-022 SHALL: latency is fixed at 34 edges: start sampled at edge 0, hi/lo valid and done=1 after edge 34.
REQ-023 SHALL: busy=1 in BUSY and FIX, busy=0 in IDLE.
REQ-024 SHALL: start is accepted on the same edge that ends FIX.
REQ-025 SHALL: start while busy=1 is ignored.
REQ-026 SHALL: divisor zero still takes full latency and yields LO=0xFFFFFFFF, HI=op_a.
REQ-027 SHALL: DIV 0x80000000 / 0xFFFFFFFF yields LO=0x80000000, HI=0.
REQ-028 SHALL: hi_we/lo_we in IDLE write wdata on that edge.
REQ-029 SHALL: hi_we/lo_we while busy=1 are ignored.
REQ-030 SHALL: start together with hi_we/lo_we in IDLE is resolved by start winning; the write is dropped.
REQ-031 SHALL: hi/lo hold their value during BUSY; partial results are internal only.

Reset
REQ-032 SHALL: reset asserted forces IDLE immediately (asynchronously), independent of clk.
REQ-033 SHALL: reset values are hi=0, lo=0, busy=0, done=0, iteration counter=0.
REQ-034 SHALL: reset mid-operation abandons the operation with no hi/lo update and no done pulse.
REQ-035 SHALL: start sampled while reset is high is ignored.

Configuration
REQ-036 SHALL: macro MIPS_MULDIV_DIV_EN compiles the divide datapath in or out.
REQ-037 SHALL: with the macro defined, DIV and DIVU operate per REQ-019..REQ-027.
REQ-038 SHALL: with the macro undefined, start with op[1]=1 goes IDLE->FIX (busy for one cycle), leaves hi/lo unchanged and pulses done; multiply is unaffected and no divider logic is synthesised.

Verification
REQ-039 SHALL: MULT op_a=0xFFFFFFFD, op_b=5 -> done after 34 edges, HI=0xFFFFFFFF, LO=0xFFFFFFF1.
REQ-040 SHALL: MULTU op_a=op_b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; start reissued at edge 10 is ignored.
REQ-041 SHALL: DIV op_a=0xFFFFFFF9, op_b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100/7 -> LO=0xE, HI=0x2.
REQ-042 SHALL: DIVU op_a=0x1234, op_b=0 -> LO=0xFFFFFFFF, HI=0x1234; the DIV 0x80000000 / -1 case is also checked.
REQ-043 SHALL: hi_we=1, wdata=0xA5A5A5A5 in IDLE -> hi=0xA5A5A5A5; lo_we during BUSY -> lo unchanged.
REQ-044 SHALL: reset pulse at edge 15 of a MULT after a prior result -> busy=0, hi=lo=0 immediately, and no done pulse follows.

Source files
------------

// File: rtl/mips_cpu_muldiv.sv
// MIPS HI/LO multiply/divide unit: 32-iteration radix-2 shift-add multiply and restoring divide.
// Define MIPS_MULDIV_DIV_EN to build the divide datapath; without it DIV/DIVU complete at once with HI/LO untouched.
module mips_cpu_muldiv (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_FIX = 2'd2} state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        isdiv_q, isdiv_d;
  logic        neg_q, neg_d;
  logic [31:0] b_q, b_d;
  logic [63:0] p_q, p_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        done_q, done_d;

  logic        is_signed, accept;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum;
  logic [63:0] mul_next, prod_fix;

  assign is_signed = ~op[0];
  assign a_mag     = (is_signed && op_a[31]) ? -op_a : op_a;
  assign b_mag     = (is_signed && op_b[31]) ? -op_b : op_b;
  assign accept    = start && ((state_q == S_IDLE) || (state_q == S_FIX));

  // p_q holds {partial product, remaining multiplier bits}; one multiplier bit retires per step
  assign mul_sum  = {1'b0, p_q[63:32]} + (p_q[0] ? {1'b0, b_q} : 33'd0);
  assign mul_next = {mul_sum, p_q[31:1]};
  assign prod_fix = neg_q ? -p_q : p_q;

`ifdef MIPS_MULDIV_DIV_EN
  logic        rneg_q, rneg_d;
  logic [32:0] div_tr;
  logic        div_ge;
  logic [31:0] div_diff;
  logic [63:0] div_next;
  logic [31:0] quo_fix, rem_fix;

  // p_q holds {remainder, dividend/quotient}; trial value is the remainder shifted left by one
  assign div_tr   = p_q[63:31];
  assign div_ge   = div_tr[32] | (div_tr[31:0] >= b_q);
  assign div_diff = div_tr[31:0] - b_q;
  assign div_next = div_ge ? {div_diff, p_q[30:0], 1'b1} : {p_q[62:0], 1'b0};
  assign quo_fix  = neg_q  ? -p_q[31:0]  : p_q[31:0];
  assign rem_fix  = rneg_q ? -p_q[63:32] : p_q[63:32];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rneg_q <= 1'b0;
    else       rneg_q <= rneg_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    isdiv_d = isdiv_q;
    neg_d   = neg_q;
    b_d     = b_q;
    p_d     = p_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
`ifdef MIPS_MULDIV_DIV_EN
    rneg_d  = rneg_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!start) begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end
      S_BUSY: begin
        if (cnt_q == 6'd32) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q + 6'd1;
`ifdef MIPS_MULDIV_DIV_EN
          p_d   = isdiv_q ? div_next : mul_next;
`else
          p_d   = mul_next;
`endif
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        cnt_d   = 6'd0;
        done_d  = 1'b1;
`ifdef MIPS_MULDIV_DIV_EN
        if (isdiv_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
`else
        if (!isdiv_q) {hi_d, lo_d} = prod_fix;
`endif
      end
      default: state_d = S_IDLE;
    endcase

    // a divide by zero keeps an all-ones quotient, so its sign flag is suppressed
    if (accept) begin
      isdiv_d = op[1];
      neg_d   = is_signed & (op_a[31] ^ op_b[31]) & (|op_b);
      b_d     = b_mag;
      p_d     = {32'd0, a_mag};
      cnt_d   = 6'd0;
`ifdef MIPS_MULDIV_DIV_EN
      rneg_d  = is_signed & op_a[31];
      state_d = S_BUSY;
`else
      state_d = op[1] ? S_FIX : S_BUSY;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
      isdiv_q <= 1'b0;
      neg_q   <= 1'b0;
      b_q     <= 32'd0;
      p_q     <= 64'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      isdiv_q <= isdiv_d;
      neg_q   <= neg_d;
      b_q     <= b_d;
      p_q     <= p_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
